// File: rtl/exu_div_pkg.sv
// Shared definitions for the execute-stage divide unit: ALU sel codes,
// the divider FSM state enum and a small op decoder.
package exu_div_pkg;

  // Divide/remainder sel codes, same encoding as the execute-stage ALU
  localparam logic [4:0] ALU_DIV   = 5'd3;
  localparam logic [4:0] ALU_DIVU  = 5'd4;
  localparam logic [4:0] ALU_REM   = 5'd5;
  localparam logic [4:0] ALU_REMU  = 5'd6;
  localparam logic [4:0] ALU_DIVW  = 5'd25;
  localparam logic [4:0] ALU_DIVUW = 5'd26;
  localparam logic [4:0] ALU_REMW  = 5'd27;
  localparam logic [4:0] ALU_REMUW = 5'd28;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } divState_e;

  typedef struct packed {
    logic supported;
    logic isWord;
    logic isSigned;
    logic isRem;
  } divOp_t;

  // Splits a sel code into the attributes the datapath cares about
  function automatic divOp_t decodeDivOp(input logic [4:0] sel);
    divOp_t op;
    op = '0;
    case (sel)
      ALU_DIV:   op = '{supported: 1'b1, isWord: 1'b0, isSigned: 1'b1, isRem: 1'b0};
      ALU_DIVU:  op = '{supported: 1'b1, isWord: 1'b0, isSigned: 1'b0, isRem: 1'b0};
      ALU_REM:   op = '{supported: 1'b1, isWord: 1'b0, isSigned: 1'b1, isRem: 1'b1};
      ALU_REMU:  op = '{supported: 1'b1, isWord: 1'b0, isSigned: 1'b0, isRem: 1'b1};
      ALU_DIVW:  op = '{supported: 1'b1, isWord: 1'b1, isSigned: 1'b1, isRem: 1'b0};
      ALU_DIVUW: op = '{supported: 1'b1, isWord: 1'b1, isSigned: 1'b0, isRem: 1'b0};
      ALU_REMW:  op = '{supported: 1'b1, isWord: 1'b1, isSigned: 1'b1, isRem: 1'b1};
      ALU_REMUW: op = '{supported: 1'b1, isWord: 1'b1, isSigned: 1'b0, isRem: 1'b1};
      default:   op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/exu_div_if.sv
// Request/response handshake bundle between the execute stage and the
// divide unit. The execute stage is the master, the divider the slave.
interface exu_div_if #(parameter int N = 64) ();
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   sel;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res;

  modport master (
    output in_valid, sel, A, B, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, sel, A, B, out_ready,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/exu_div_core.sv
// Unsigned restoring radix-2 divider. start_i loads the operands and a step
// count; one quotient bit is produced per cycle. done_o is high during the
// final step, and quotient_o/remainder_o then carry the finished result, so
// the caller can capture it on that same edge.
module div_core #(
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [$clog2(W+1)-1:0]   steps_i,
  input  logic [W-1:0]             dividend_i,
  input  logic [W-1:0]             divisor_i,
  output logic                     done_o,
  output logic [W-1:0]             quotient_o,
  output logic [W-1:0]             remainder_o
);
  localparam int CW = $clog2(W+1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  div_q;

  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  remNext;
  logic [W-1:0]  quoNext;

  // One restoring step: shift the next dividend bit in, subtract if it fits
  always_comb begin
    trial   = {rem_q, quo_q[W-1]};
    ge      = (trial >= {1'b0, div_q});
    remNext = ge ? (trial[W-1:0] - div_q) : trial[W-1:0];
    quoNext = {quo_q[W-2:0], ge};
  end

  assign done_o      = busy_q && (cnt_q == CW'(1));
  assign quotient_o  = quoNext;
  assign remainder_o = remNext;

  // Operand load and per-cycle iteration; abort drops the op immediately
  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= steps_i;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      div_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= remNext;
      quo_q <= quoNext;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exu_div.sv
// Multi-cycle divide/remainder unit for the execute stage. Handles the
// handshake, special cases (divide by zero, signed overflow, unknown sel),
// sign handling around the unsigned core and 32-bit word forms.
module exu_div
  import exu_div_pkg::*;
#(
  parameter int N = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  exu_div_if.slave io
);
  localparam int CW = $clog2(N+1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] sext32(input logic [31:0] x);
    return {{(N-32){x[31]}}, x};
  endfunction

  function automatic logic [N-1:0] zext32(input logic [31:0] x);
    return {{(N-32){1'b0}}, x};
  endfunction

  divState_e     state_q, state_d;

  divOp_t        op;
  logic [N-1:0]  aExt, bExt, aMag, bMag;
  logic          aNeg, bNeg;
  logic          divZero, overflow, isSpecial;
  logic [N-1:0]  specialRes;
  logic [N-1:0]  coreDividend;
  logic [CW-1:0] steps;

  logic          coreStart, loadSpecial, loadCore;
  logic          coreDone;
  logic [N-1:0]  coreQuo, coreRem;

  logic          isWord_q, isRem_q, negQuo_q, negRem_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  postQuo, postRem, postSel, postRes;

  // Decode the offered op, extend W-form operands and spot special cases
  always_comb begin
    op = decodeDivOp(io.sel);
    if (op.isWord) begin
      aExt = op.isSigned ? sext32(io.A[31:0]) : zext32(io.A[31:0]);
      bExt = op.isSigned ? sext32(io.B[31:0]) : zext32(io.B[31:0]);
    end else begin
      aExt = io.A;
      bExt = io.B;
    end
    aNeg = op.isSigned && aExt[N-1];
    bNeg = op.isSigned && bExt[N-1];
    aMag = aNeg ? -aExt : aExt;
    bMag = bNeg ? -bExt : bExt;

    divZero   = (bExt == '0);
    overflow  = op.isSigned && (bExt == '1) &&
                (aExt == (op.isWord ? sext32(32'h8000_0000) : MOST_NEG));
    isSpecial = !op.supported || divZero || overflow;

    specialRes = '0;
    if (op.supported) begin
      if (divZero) begin
        specialRes = op.isRem ? (op.isWord ? sext32(io.A[31:0]) : io.A) : '1;
      end else if (overflow) begin
        specialRes = op.isRem ? '0 : aExt;
      end
    end

    coreDividend = op.isWord ? (aMag << (N-32)) : aMag;
    steps        = op.isWord ? CW'(32) : CW'(N);
  end

  div_core #(.W(N)) u_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (coreStart),
    .abort_i     (flush),
    .steps_i     (steps),
    .dividend_i  (coreDividend),
    .divisor_i   (bMag),
    .done_o      (coreDone),
    .quotient_o  (coreQuo),
    .remainder_o (coreRem)
  );

  // Restore signs on the core result and sign-extend word-form results
  always_comb begin
    postQuo = negQuo_q ? -coreQuo : coreQuo;
    postRem = negRem_q ? -coreRem : coreRem;
    postSel = isRem_q ? postRem : postQuo;
    postRes = isWord_q ? sext32(postSel[31:0]) : postSel;
  end

  // Next-state and control strobes; flush overrides everything
  always_comb begin
    state_d     = state_q;
    coreStart   = 1'b0;
    loadSpecial = 1'b0;
    loadCore    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (io.in_valid) begin
          if (isSpecial) begin
            loadSpecial = 1'b1;
            state_d     = DIV_DONE;
          end else begin
            coreStart = 1'b1;
            state_d   = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        if (coreDone) begin
          loadCore = 1'b1;
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (io.out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush) begin
      state_d     = DIV_IDLE;
      coreStart   = 1'b0;
      loadSpecial = 1'b0;
      loadCore    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch op attributes at accept and capture the result into the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      isWord_q <= 1'b0;
      isRem_q  <= 1'b0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
      res_q    <= '0;
    end else begin
      if (coreStart) begin
        isWord_q <= op.isWord;
        isRem_q  <= op.isRem;
        negQuo_q <= aNeg ^ bNeg;
        negRem_q <= aNeg;
      end
      if (loadSpecial) begin
        res_q <= specialRes;
      end else if (loadCore) begin
        res_q <= postRes;
      end
    end
  end

  assign io.in_ready  = (state_q == DIV_IDLE);
  assign io.out_valid = (state_q == DIV_DONE);
  assign io.res       = res_q;

endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: expected results come from a behavioural
// model built on SV division operators and flow through a scoreboard queue.
module tb_exu_div;
  import exu_div_pkg::*;

  typedef struct {
    logic [4:0]  sel;
    logic [63:0] a;
    logic [63:0] b;
  } stim_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } expEntry_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int checks   = 0;
  int failures = 0;

  expEntry_t   sbQueue[$];
  stim_t       dirTab[$];
  logic [63:0] lastExpRes;

  always #5 clk = ~clk;

  exu_div_if #(.N(64)) io ();

  exu_div #(.N(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (io)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] modelRes(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] ua, ub, r32;
    logic ovf64, ovf32, isW;
    logic [63:0] r;
    sa = a; sb = b;
    wa = a[31:0]; wb = b[31:0];
    ua = a[31:0]; ub = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
    r = '0; r32 = '0; isW = 1'b0;
    case (s)
      ALU_DIV:  if (b == 0) r = '1; else if (ovf64) r = a; else r = sa / sb;
      ALU_DIVU: if (b == 0) r = '1; else r = a / b;
      ALU_REM:  if (b == 0) r = a; else if (ovf64) r = '0; else r = sa % sb;
      ALU_REMU: if (b == 0) r = a; else r = a % b;
      ALU_DIVW: begin isW = 1'b1; if (ub == 0) r32 = '1; else if (ovf32) r32 = ua; else r32 = wa / wb; end
      ALU_DIVUW: begin isW = 1'b1; if (ub == 0) r32 = '1; else r32 = ua / ub; end
      ALU_REMW: begin isW = 1'b1; if (ub == 0) r32 = ua; else if (ovf32) r32 = '0; else r32 = wa % wb; end
      ALU_REMUW: begin isW = 1'b1; if (ub == 0) r32 = ua; else r32 = ua % ub; end
      default: r = '0;
    endcase
    if (isW) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  function automatic int modelLat(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b);
    logic ovf64, ovf32;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    case (s)
      ALU_DIVU, ALU_REMU:   return (b == 0) ? 1 : 65;
      ALU_DIV, ALU_REM:     return ((b == 0) || ovf64) ? 1 : 65;
      ALU_DIVUW, ALU_REMUW: return (b[31:0] == 0) ? 1 : 33;
      ALU_DIVW, ALU_REMW:   return ((b[31:0] == 0) || ovf32) ? 1 : 33;
      default:              return 1;
    endcase
  endfunction

  // Offer one op and hold it until the accept edge; returns just after that edge
  task automatic applyStimulus(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b, input bit expectResult);
    expEntry_t e;
    int waitCnt;
    @(negedge clk);
    io.sel = s; io.A = a; io.B = b; io.in_valid = 1'b1;
    waitCnt = 0;
    while (!io.in_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("acceptReady", 64'(io.in_ready), 64'd1);
    if (expectResult) begin
      e.res = modelRes(s, a, b);
      e.lat = modelLat(s, a, b);
      sbQueue.push_back(e);
    end
    @(posedge clk);
    #1 io.in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen
  task automatic waitResult(output int lat);
    lat = 1;
    @(negedge clk);
    while (!io.out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkResult(input string tag);
    expEntry_t e;
    int lat;
    waitResult(lat);
    checkOutput({tag, ".outValid"}, 64'(io.out_valid), 64'd1);
    checkOutput({tag, ".sbNotEmpty"}, 64'(sbQueue.size() != 0), 64'd1);
    if (sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      lastExpRes = e.res;
      checkOutput({tag, ".res"}, io.res, e.res);
      checkOutput({tag, ".lat"}, 64'(lat), 64'(e.lat));
    end
    if (io.out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence
  initial begin
    logic [4:0] randSels [10];
    bit sawValid;
    rst = 1'b1; flush = 1'b0;
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    io.sel = '0; io.A = '0; io.B = '0;
    lastExpRes = '0;
    randSels = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_DIVW,
                 ALU_DIVUW, ALU_REMW, ALU_REMUW, 5'd0, 5'd7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 64'(io.in_ready), 64'd1);
    checkOutput("rstOutValid", 64'(io.out_valid), 64'd0);
    checkOutput("rstRes", io.res, 64'd0);
    rst = 1'b0;

    dirTab.push_back('{ALU_DIVU, 64'd100, 64'd7});
    dirTab.push_back('{ALU_REMU, 64'd100, 64'd7});
    dirTab.push_back('{ALU_DIV, -64'sd7, 64'd2});
    dirTab.push_back('{ALU_REM, -64'sd7, 64'd2});
    dirTab.push_back('{ALU_REM, 64'd7, -64'sd2});
    dirTab.push_back('{ALU_DIV, 64'd5, 64'd0});
    dirTab.push_back('{ALU_REM, 64'd5, 64'd0});
    dirTab.push_back('{ALU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF});
    dirTab.push_back('{ALU_REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF});
    dirTab.push_back('{ALU_DIVUW, 64'h1_0000_0010, 64'h1_0000_0003});
    dirTab.push_back('{ALU_DIVUW, 64'h1_0000_0010, 64'h1_0000_0000});
    dirTab.push_back('{ALU_DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF});
    dirTab.push_back('{ALU_REMUW, 64'h0000_0000_FFFF_FFFF, 64'd7});
    dirTab.push_back('{ALU_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1});
    dirTab.push_back('{5'd0, 64'd5, 64'd3});

    foreach (dirTab[i]) begin
      applyStimulus(dirTab[i].sel, dirTab[i].a, dirTab[i].b, 1'b1);
      checkResult($sformatf("dir%0d", i));
    end

    // Backpressure: result must hold while out_ready is low
    io.out_ready = 1'b0;
    applyStimulus(ALU_DIV, -64'sd1000, 64'd33, 1'b1);
    checkResult("hold");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("holdRes%0d", k), io.res, lastExpRes);
      checkOutput($sformatf("holdInReady%0d", k), 64'(io.in_ready), 64'd0);
      checkOutput($sformatf("holdOutValid%0d", k), 64'(io.out_valid), 64'd1);
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("holdRelease", 64'(io.out_valid), 64'd0);
    checkOutput("holdIdle", 64'(io.in_ready), 64'd1);

    // Flush in IDLE suppresses the accept
    @(negedge clk);
    io.sel = ALU_DIVU; io.A = 64'd50; io.B = 64'd5; io.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("idleFlushReady", 64'(io.in_ready), 64'd1);
    checkOutput("idleFlushValid", 64'(io.out_valid), 64'd0);

    // Flush during CALC drops the op
    applyStimulus(ALU_DIVU, 64'd1000, 64'd3, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("calcFlushReady", 64'(io.in_ready), 64'd1);
    sawValid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (io.out_valid) sawValid = 1'b1;
    end
    checkOutput("calcFlushNoValid", 64'(sawValid), 64'd0);

    // Reset in the middle of an op returns to the reset state
    applyStimulus(ALU_REMU, 64'd12345, 64'd11, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", 64'(io.in_ready), 64'd1);
    checkOutput("midRstValid", 64'(io.out_valid), 64'd0);
    checkOutput("midRstRes", io.res, 64'd0);

    // Random ops after the flushes and reset
    for (int i = 0; i < 20; i++) begin
      logic [4:0]  s;
      logic [63:0] a, b;
      int pick;
      s = randSels[$urandom_range(0, 9)];
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      pick = $urandom_range(0, 5);
      case (pick)
        0: b = 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 100));
        3: begin a = 64'h8000_0000_8000_0000; b = '1; end
        default: ;
      endcase
      applyStimulus(s, a, b, 1'b1);
      checkResult($sformatf("rnd%0d", i));
    end

    checkOutput("sbDrained", 64'(sbQueue.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
